// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
// Line levels and the baud divisor helper are reused by the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  function automatic int calc_clks_per_bit(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the UART transmitter.
// Pointers carry an extra MSB so full and empty are distinguishable.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = wr_ptr == rd_ptr;
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: FIFO-buffered bytes serialised LSB first, 8N1 default.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_START  = 3'(START);
  localparam logic [2:0] ST_DATA   = 3'(DATA);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'(PARITY);
`endif
  localparam logic [2:0] ST_STOP   = 3'(STOP);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_unit: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_width
    $error("uart_tx_unit: DATA_BITS must be 5..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_unit: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [2:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tx_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] pop_data;
  logic                 push;
  logic                 pop;
  logic                 baud_done;
  logic                 last_bit;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign baud_done = baud_cnt == CW'(CLKS_PER_BIT - 1);
  assign last_bit  = bit_cnt == BW'(DATA_BITS - 1);
  // Pop from IDLE, or at the end of STOP so frames run back to back.
  assign pop       = !fifo_empty &&
                     ((state == ST_IDLE) ||
                      (state == ST_STOP && baud_done));

  assign tx   = tx_q;
  assign busy = (state != ST_IDLE) || (fifo_count != '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_q     <= UART_IDLE_LEVEL;
    end else begin
      baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
      unique case (1'b1)
        state == ST_IDLE: begin
          baud_cnt <= '0;
          tx_q     <= UART_IDLE_LEVEL;
          if (pop) begin
            shift   <= pop_data;
            bit_cnt <= '0;
            tx_q    <= UART_START_LEVEL;
            state   <= ST_START;
          end
        end
        state == ST_START: begin
          if (baud_done) begin
            tx_q  <= shift[0];
            state <= ST_DATA;
          end
        end
        state == ST_DATA: begin
          if (baud_done) begin
            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= parity_q;
              state <= ST_PARITY;
`else
              tx_q  <= UART_IDLE_LEVEL;
              state <= ST_STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx_q    <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        state == ST_PARITY: begin
          if (baud_done) begin
            tx_q  <= UART_IDLE_LEVEL;
            state <= ST_STOP;
          end
        end
`endif
        state == ST_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift   <= pop_data;
              bit_cnt <= '0;
              tx_q    <= UART_START_LEVEL;
              state   <= ST_START;
            end else begin
              tx_q  <= UART_IDLE_LEVEL;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_q  <= UART_IDLE_LEVEL;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else if (pop) parity_q <= ^pop_data;
  end
`endif

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit against a line-level waveform model.
// Define UART_TX_PARITY_EN to also exercise the parity frame.
module tb_uart_tx_unit;

  localparam int CLK_FREQ  = 40;
  localparam int BAUD_RATE = 10;
  localparam int DBITS     = 8;
  localparam int DEPTH     = 4;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queued words, remaining line levels of the current frame.
  logic       m_tx;
  bit         m_rem[$];
  logic [7:0] m_q[$];
  bit         m_in_frame;

  always #5 clk = ~clk;

  uart_tx_unit #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_BITS  (DBITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  function automatic void load_frame(input logic [7:0] d);
    for (int c = 0; c < CPB; c++) m_rem.push_back(1'b0);
    for (int b = 0; b < DBITS; b++)
      for (int c = 0; c < CPB; c++) m_rem.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) m_rem.push_back(^d);
`endif
    for (int c = 0; c < CPB; c++) m_rem.push_back(1'b1);
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    int sz;
    in_valid = v;
    in_data  = d;
    reset    = r;
    @(posedge clk);
    if (r) begin
      m_tx = 1'b1;
      m_rem.delete();
      m_q.delete();
      m_in_frame = 1'b0;
    end else begin
      sz = m_q.size();
      if (m_rem.size() == 0) begin
        if (sz > 0) begin
          load_frame(m_q.pop_front());
          m_tx = m_rem.pop_front();
          m_in_frame = 1'b1;
        end else begin
          m_tx = 1'b1;
          m_in_frame = 1'b0;
        end
      end else begin
        m_tx = m_rem.pop_front();
      end
      if (v && sz < DEPTH) m_q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    n_checks += 4;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_idle_line();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      n_checks += 3;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx: got %b want 1 cyc %0d", tx, i); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0 cyc %0d", busy, i); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1 cyc %0d", in_ready, i); end
    end
  endtask

  task automatic test_single_byte();
    int busy_cycles = 0;
    step(1'b1, 8'hA5, 1'b0);
    for (int i = 1; i <= 50; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (busy === 1'b1) busy_cycles++;
      n_checks += 2;
      if (tx !== m_tx) begin n_fail++; $display("FAIL single_tx: got %b want %b cyc %0d", tx, m_tx, i); end
      if (busy !== (m_in_frame || m_q.size() != 0)) begin
        n_fail++; $display("FAIL single_busy: got %b cyc %0d", busy, i);
      end
    end
    n_checks++;
    if (busy_cycles != 40) begin
      n_fail++; $display("FAIL single_busy_len: got %0d want 40", busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int peak = 0;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h55;
    for (int i = 0; i < 3 + 3 * 40 + 10; i++) begin
      if (i < 3) step(1'b1, words[i], 1'b0);
      else step(1'b0, 8'h00, 1'b0);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      n_checks += 2;
      if (tx !== m_tx) begin n_fail++; $display("FAIL b2b_tx: got %b want %b cyc %0d", tx, m_tx, i); end
      if (fifo_count !== 3'(m_q.size())) begin
        n_fail++; $display("FAIL b2b_count: got %0d want %0d cyc %0d", fifo_count, m_q.size(), i);
      end
    end
    n_checks++;
    if (peak != 2) begin n_fail++; $display("FAIL b2b_peak: got %0d want 2", peak); end
  endtask

  task automatic test_full_fifo();
    logic [7:0] d = 8'($urandom);
    for (int i = 0; i < 5 * 40 + 30; i++) begin
      if (i < 20) begin
        step(1'b1, d, 1'b0);
        d = d + 8'd1;
      end else begin
        step(1'b0, 8'h00, 1'b0);
      end
      if (i == 4) begin
        n_checks += 2;
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_drop: got %b want 0", in_ready); end
      end
      n_checks += 4;
      if (tx !== m_tx) begin n_fail++; $display("FAIL full_tx: got %b want %b cyc %0d", tx, m_tx, i); end
      if (in_ready !== (m_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL full_ready: got %b cyc %0d", in_ready, i);
      end
      if (fifo_count !== 3'(m_q.size())) begin
        n_fail++; $display("FAIL full_fifo_count: got %0d want %0d cyc %0d", fifo_count, m_q.size(), i);
      end
      if (busy !== (m_in_frame || m_q.size() != 0)) begin
        n_fail++; $display("FAIL full_busy: got %b cyc %0d", busy, i);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    repeat (15) step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL midrst_queued: got %0d want 2", fifo_count); end
    step(1'b0, 8'h00, 1'b1);
    n_checks += 2;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx); end
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", fifo_count); end
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 8'h00, 1'b0);
      n_checks += 2;
      if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_after_tx: got %b want 1 cyc %0d", tx, i); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_after_busy: got %b want 0 cyc %0d", busy, i); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    step(1'b1, 8'h07, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      if (i == 1) step(1'b1, 8'h03, 1'b0);
      else step(1'b0, 8'h00, 1'b0);
      if (i >= 37 && i <= 40) begin
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL parity_07: got %b want 1 cyc %0d", tx, i); end
      end
      if (i >= 81 && i <= 84) begin
        n_checks++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL parity_03: got %b want 0 cyc %0d", tx, i); end
      end
      n_checks++;
      if (tx !== m_tx) begin n_fail++; $display("FAIL parity_tx: got %b want %b cyc %0d", tx, m_tx, i); end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      if (i < 900) step($urandom_range(0, 5) == 0, 8'($urandom), 1'b0);
      else step(1'b0, 8'h00, 1'b0);
      n_checks += 4;
      if (tx !== m_tx) begin n_fail++; $display("FAIL rand_tx: got %b want %b cyc %0d", tx, m_tx, i); end
      if (in_ready !== (m_q.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_ready: got %b cyc %0d", in_ready, i);
      end
      if (fifo_count !== 3'(m_q.size())) begin
        n_fail++; $display("FAIL rand_count: got %0d want %0d cyc %0d", fifo_count, m_q.size(), i);
      end
      if (busy !== (m_in_frame || m_q.size() != 0)) begin
        n_fail++; $display("FAIL rand_busy: got %b cyc %0d", busy, i);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    m_tx       = 1'b1;
    m_in_frame = 1'b0;
    test_reset();
    test_idle_line();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
